// File: rtl/mips_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_pkg
// Definitions shared across the MIPS CPU data path:
//   - mem_size_t   : load/store access size encoding (byte/half/word/illegal)
//   - lsu_state_t  : load/store unit FSM state encoding
//   - is_aligned() : natural-alignment check for an access size and addr[1:0]
// -----------------------------------------------------------------------------
package mips_cpu_pkg;

    typedef logic [1:0] mem_size_t;

    localparam mem_size_t SIZE_BYTE    = 2'd0;
    localparam mem_size_t SIZE_HALF    = 2'd1;
    localparam mem_size_t SIZE_WORD    = 2'd2;
    localparam mem_size_t SIZE_ILLEGAL = 2'd3;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE   = 2'd0;
    localparam lsu_state_t ST_ACCESS = 2'd1;
    localparam lsu_state_t ST_DONE   = 2'd2;

    // True when an access of the given size at this byte offset is naturally
    // aligned. The illegal size encoding is never aligned.
    function automatic logic is_aligned(input mem_size_t size, input logic [1:0] lo);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~lo[0];
            SIZE_WORD: ok = (lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_aligner.sv
// -----------------------------------------------------------------------------
// store_aligner
// Combinational store lane steering: replicates the stored byte/halfword into
// every lane of the 32-bit bus and selects the matching byte enables.
//   mem_size   (in)  access size (mips_cpu_pkg encoding)
//   addr_lo    (in)  byte offset within the word, addr[1:0]
//   store_data (in)  rt value to store, right-justified
//   byteenable (out) active lanes for the write
//   writedata  (out) lane-replicated write data
// -----------------------------------------------------------------------------
module store_aligner
    import mips_cpu_pkg::*;
(
    input  mem_size_t   mem_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata
);

    always_comb begin
        // NOTE: defaults first so every path through the case assigns both
        // outputs; a missing assignment here would infer a latch.
        byteenable = 4'h0;
        writedata  = store_data;
        case (mem_size)
            SIZE_BYTE: begin
                byteenable = 4'b0001 << addr_lo;
                writedata  = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
                writedata  = {2{store_data[15:0]}};
            end
            SIZE_WORD: begin
                byteenable = 4'hF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Turns a load/store request from the pipeline into a single Avalon-MM bus
// transfer. FSM: IDLE -> ACCESS (held while waitrequest) -> DONE -> IDLE.
// Misaligned or contradictory requests raise addr_error and never reach the bus.
//   clk, reset_n          clock, asynchronous active-low reset
//   mem_read, mem_write   request from control (load / store)
//   mem_size, addr        access size and byte address (ALU result)
//   store_data            rt value for stores
//   avm_*                 Avalon-MM data master
//   data_readdata         registered full read word for write-back
//   byte_addressing       registered addr[1:0] of the completed access
//   stall                 freezes PC and pipeline while an access is pending
//   done                  one-cycle completion pulse
//   addr_error            one-cycle illegal-request pulse
// -----------------------------------------------------------------------------
module load_store_unit
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  mem_size_t   mem_size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] data_readdata,
    output logic [1:0]  byte_addressing,
    output logic        stall,
    output logic        done,
    output logic        addr_error
);

    lsu_state_t  state;
    logic        is_write;
    logic        req_any;
    logic        req_valid;
    logic        req_illegal;
    logic [3:0]  st_byteenable;
    logic [31:0] st_writedata;

    // Asserting both strobes at once is treated as illegal, like misalignment.
    assign req_any     = mem_read | mem_write;
    assign req_valid   = (mem_read ^ mem_write) && is_aligned(mem_size, addr[1:0]);
    assign req_illegal = req_any && !req_valid;

    store_aligner u_store_aligner (
        .mem_size   (mem_size),
        .addr_lo    (addr[1:0]),
        .store_data (store_data),
        .byteenable (st_byteenable),
        .writedata  (st_writedata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            is_write        <= 1'b0;
            avm_address     <= '0;
            avm_byteenable  <= '0;
            avm_writedata   <= '0;
            data_readdata   <= '0;
            byte_addressing <= '0;
            addr_error      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // updates from the values present before this clock edge.
            addr_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        avm_address     <= {addr[31:2], 2'b00};
                        avm_byteenable  <= mem_write ? st_byteenable : 4'hF;
                        avm_writedata   <= mem_write ? st_writedata : 32'h0;
                        byte_addressing <= addr[1:0];
                        is_write        <= mem_write;
                        state           <= ST_ACCESS;
                    end else if (req_illegal) begin
                        addr_error <= 1'b1;
                    end
                end
                // Request inputs are not looked at here; the latched copy
                // keeps the bus stable while the slave stretches the cycle.
                ST_ACCESS: begin
                    if (!avm_waitrequest) begin
                        if (!is_write) begin
                            data_readdata <= avm_readdata;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode from state alone, so an asynchronous reset that forces
    // IDLE drops them immediately; is_write makes them mutually exclusive.
    assign avm_read  = (state == ST_ACCESS) && !is_write;
    assign avm_write = (state == ST_ACCESS) &&  is_write;
    assign done      = (state == ST_DONE);
    assign stall     = ((state == ST_IDLE) && req_valid) || (state == ST_ACCESS);

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Table of directed transactions followed by randomized transactions whose
// expectations come from an arithmetic model of the access rules.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] data_readdata;
    logic [1:0]  byte_addressing;
    logic        stall;
    logic        done;
    logic        addr_error;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rd;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          waits;
        logic        err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl[12];

    load_store_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_size        (mem_size),
        .addr            (addr),
        .store_data      (store_data),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .data_readdata   (data_readdata),
        .byte_addressing (byte_addressing),
        .stall           (stall),
        .done            (done),
        .addr_error      (addr_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = 2'd0;
        addr       = 32'h0;
        store_data = 32'h0;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rdata, input int waits, input logic err,
                                input logic [31:0] ea, input logic [3:0] ebe,
                                input logic [31:0] ewd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.addr = a; v.sd = sd;
        v.rdata = rdata; v.waits = waits; v.err = err;
        v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd;
        return v;
    endfunction

    // Reference model: an access of 2**size bytes is legal when exactly one
    // direction is requested and the address is a multiple of the access size.
    // Stores occupy the lanes starting at the byte offset; the data element is
    // replicated by multiplying with a lane-repeat constant.
    function automatic vec_t model(input logic rd, input logic wr, input logic [1:0] size,
                                   input logic [31:0] a, input logic [31:0] sd,
                                   input logic [31:0] rdata, input int waits);
        vec_t        v;
        int          nbytes;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] rep;
        nbytes = 1 << size;
        legal  = (rd != wr) && (size != 2'd3) && ((a % nbytes) == 0);
        v.rd = rd; v.wr = wr; v.size = size; v.addr = a; v.sd = sd;
        v.rdata = rdata; v.waits = waits;
        v.err      = (rd || wr) && !legal;
        v.exp_addr = a & 32'hFFFF_FFFC;
        v.exp_be   = 4'hF;
        v.exp_wdata = 32'h0;
        if (wr && legal) begin
            v.exp_be  = 4'(((1 << nbytes) - 1) << (a % 4));
            mask      = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            rep       = (nbytes == 1) ? 32'h0101_0101 : (nbytes == 2) ? 32'h0001_0001 : 32'd1;
            v.exp_wdata = (sd & mask) * rep;
        end
        return v;
    endfunction

    // Runs one transaction starting from IDLE. The slave holds waitrequest for
    // v.waits cycles; request inputs are scrambled while the access is pending
    // and a valid request is offered during DONE, which must not be taken.
    task automatic do_txn(input vec_t v, input string tag);
        logic legal;
        legal = (v.rd || v.wr) && !v.err;
        step();
        mem_read        = v.rd;
        mem_write       = v.wr;
        mem_size        = v.size;
        addr            = v.addr;
        store_data      = v.sd;
        avm_waitrequest = (v.waits > 0);
        avm_readdata    = v.rdata;
        @(negedge clk);
        check({tag, " stall_idle"}, 32'(stall), 32'(legal));
        if (legal) begin
            step();
            for (int k = 0; k <= v.waits; k++) begin
                mem_read        = 1'($urandom);
                mem_write       = 1'($urandom);
                mem_size        = 2'($urandom);
                addr            = $urandom;
                store_data      = $urandom;
                avm_waitrequest = (k < v.waits);
                avm_readdata    = (k < v.waits) ? $urandom : v.rdata;
                @(negedge clk);
                check($sformatf("%s acc%0d avm_read", tag, k), 32'(avm_read), 32'(v.rd));
                check($sformatf("%s acc%0d avm_write", tag, k), 32'(avm_write), 32'(v.wr));
                check($sformatf("%s acc%0d avm_address", tag, k), avm_address, v.exp_addr);
                check($sformatf("%s acc%0d byteenable", tag, k), 32'(avm_byteenable), 32'(v.exp_be));
                if (v.wr) begin
                    check($sformatf("%s acc%0d writedata", tag, k), avm_writedata, v.exp_wdata);
                end
                check($sformatf("%s acc%0d stall", tag, k), 32'(stall), 32'd1);
                check($sformatf("%s acc%0d done", tag, k), 32'(done), 32'd0);
                step();
            end
            // DONE cycle: offer a valid load that must be ignored.
            mem_read        = 1'b1;
            mem_write       = 1'b0;
            mem_size        = 2'd2;
            addr            = 32'h0000_0040;
            avm_waitrequest = 1'b0;
            if (v.rd) exp_rd = v.rdata;
            @(negedge clk);
            check({tag, " done"}, 32'(done), 32'd1);
            check({tag, " stall_done"}, 32'(stall), 32'd0);
            check({tag, " strobes_done"}, 32'({avm_read, avm_write}), 32'd0);
            check({tag, " data_readdata"}, data_readdata, exp_rd);
            check({tag, " byte_addressing"}, 32'(byte_addressing), 32'(v.addr[1:0]));
            step();
            clear_inputs();
            @(negedge clk);
            check({tag, " done_after"}, 32'(done), 32'd0);
            check({tag, " no_accept_in_done"}, 32'({avm_read, avm_write}), 32'd0);
        end else begin
            check({tag, " strobes_req"}, 32'({avm_read, avm_write}), 32'd0);
            step();
            clear_inputs();
            @(negedge clk);
            check({tag, " addr_error"}, 32'(addr_error), 32'(v.err));
            check({tag, " strobes_err"}, 32'({avm_read, avm_write}), 32'd0);
            check({tag, " stall_err"}, 32'(stall), 32'd0);
            step();
            @(negedge clk);
            check({tag, " addr_error_end"}, 32'(addr_error), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        int   sel;

        tbl[0]  = mk(1, 0, 2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'h0000_1004, 4'hF, 32'h0);
        tbl[1]  = mk(0, 1, 0, 32'h0000_2003, 32'h0000_00A5, 32'h0, 0, 0, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5);
        tbl[2]  = mk(1, 0, 1, 32'h0000_1001, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0);
        tbl[3]  = mk(1, 0, 2, 32'h0000_1002, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0);
        tbl[4]  = mk(0, 1, 2, 32'h0000_3000, 32'h1234_5678, 32'h0, 5, 0, 32'h0000_3000, 4'hF, 32'h1234_5678);
        tbl[5]  = mk(1, 1, 2, 32'h0000_4000, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0);
        tbl[6]  = mk(0, 1, 1, 32'h0000_5002, 32'h0000_BEEF, 32'h0, 0, 0, 32'h0000_5000, 4'b1100, 32'hBEEF_BEEF);
        tbl[7]  = mk(0, 1, 1, 32'h0000_5000, 32'h1234_CAFE, 32'h0, 1, 0, 32'h0000_5000, 4'b0011, 32'hCAFE_CAFE);
        tbl[8]  = mk(0, 1, 0, 32'h0000_6001, 32'hFFFF_FF77, 32'h0, 0, 0, 32'h0000_6000, 4'b0010, 32'h7777_7777);
        tbl[9]  = mk(1, 0, 3, 32'h0000_7000, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0);
        tbl[10] = mk(1, 0, 0, 32'h0000_8003, 32'h0, 32'h1122_3344, 2, 0, 32'h0000_8000, 4'hF, 32'h0);
        tbl[11] = mk(0, 1, 2, 32'h0000_9006, 32'h5555_AAAA, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0);

        // Reset state.
        reset_n         = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0;
        clear_inputs();
        exp_rd = 32'h0;
        #12;
        check("rst avm_address", avm_address, 32'h0);
        check("rst strobes", 32'({avm_read, avm_write}), 32'd0);
        check("rst byteenable", 32'(avm_byteenable), 32'd0);
        check("rst writedata", avm_writedata, 32'h0);
        check("rst data_readdata", data_readdata, 32'h0);
        check("rst byte_addressing", 32'(byte_addressing), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst addr_error", 32'(addr_error), 32'd0);
        check("rst stall idle", 32'(stall), 32'd0);
        mem_read = 1'b1;
        mem_size = 2'd2;
        addr     = 32'h0000_0100;
        #1;
        check("rst stall with request", 32'(stall), 32'd1);
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            do_txn(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset asserted in the middle of a stretched read.
        step();
        mem_read        = 1'b1;
        mem_size        = 2'd2;
        addr            = 32'h0000_9000;
        avm_waitrequest = 1'b1;
        step();
        clear_inputs();
        @(negedge clk);
        check("midrst avm_read before", 32'(avm_read), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst avm_read", 32'(avm_read), 32'd0);
        check("midrst stall", 32'(stall), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst avm_address", avm_address, 32'h0);
        @(negedge clk);
        check("midrst done held", 32'(done), 32'd0);
        reset_n = 1'b1;
        exp_rd  = 32'h0;
        do_txn(mk(1, 0, 2, 32'h0000_A008, 32'h0, 32'hCAFE_F00D, 0, 0, 32'h0000_A008, 4'hF, 32'h0),
               "post_rst lw");

        // Randomized transactions against the model.
        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 9);
            v = model((sel <= 3) || (sel == 8), (sel >= 4 && sel <= 8), 2'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom, $urandom_range(0, 3));
            do_txn(v, $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port mem_read, input, 1, from control: the current instruction is a load.
REQ-004 SHALL have port mem_write, input, 1, from control: the current instruction is a store.
REQ-005 SHALL have port mem_size, input, 2, access size: 0=byte, 1=halfword, 2=word; 3 is illegal.
REQ-006 SHALL have port addr, input, 32, byte address taken from the ALU result.
REQ-007 SHALL have port store_data, input, 32, rt value to store.
REQ-008 SHALL have ports avm_address (output, 32), avm_read (output, 1), avm_write (output, 1), avm_byteenable (output, 4), avm_writedata (output, 32), avm_readdata (input, 32) and avm_waitrequest (input, 1), forming the data bus.
REQ-009 SHALL have port data_readdata, output, 32, the registered full read word, to the write-back selector.
REQ-010 SHALL have port byte_addressing, output, 2, the registered addr[1:0] of the completed access.
REQ-011 SHALL have ports stall (output, 1, freezes the PC and pipeline), done (output, 1, single-cycle completion pulse) and addr_error (output, 1, single-cycle misalignment pulse).

Function
REQ-012 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-013 In IDLE with exactly one of mem_read or mem_write high and the access aligned, the block SHALL latch {addr[31:2],2'b00}, byteenable, writedata, addr[1:0] and the direction, then enter ACCESS.
REQ-014 In ACCESS the block SHALL hold avm_read or avm_write high with all bus outputs stable for as long as avm_waitrequest=1.
REQ-015 In ACCESS with avm_waitrequest=0, the block SHALL capture avm_readdata into data_readdata (reads only; unchanged on writes) and enter DONE.
REQ-016 In DONE the block SHALL pulse done for one cycle, deassert the bus strobes and return to IDLE; a new request SHALL NOT be accepted in DONE.
REQ-017 Minimum latency with zero wait states SHALL be 3 cycles from request to the done pulse: IDLE, ACCESS, DONE.
REQ-018 stall SHALL be combinationally high in IDLE while a valid request is present, high throughout ACCESS, and low in DONE.
REQ-019 For reads, avm_byteenable SHALL be 4'hF.
REQ-020 For stores, byteenable and writedata SHALL be: byte -> 4'b0001<<addr[1:0] with the byte replicated to all four lanes; halfword -> 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1) with the halfword replicated; word -> 4'hF with the data as given.
REQ-021 A halfword access with addr[0]=1, a word access with addr[1:0]!=0, or mem_size=3 SHALL pulse addr_error for one cycle, perform no bus cycle, hold stall low and leave the state at IDLE.
REQ-022 If mem_read and mem_write are both high in IDLE, the block SHALL treat the request as illegal under REQ-021.
REQ-023 Changes to the request inputs during ACCESS SHALL be ignored.
REQ-024 avm_read and avm_write SHALL never be high together.

Reset
REQ-025 While reset_n=0 the block SHALL force state IDLE, avm_read=0, avm_write=0, avm_address=0, avm_byteenable=0, avm_writedata=0, data_readdata=0, byte_addressing=0, done=0 and addr_error=0, and SHALL hold stall low unless a request is present.
REQ-026 Reset asserted during ACCESS SHALL abort the bus cycle immediately with no done pulse.

Structure
REQ-027 The mem_size encoding and the FSM state type SHALL live in the shared package mips_cpu_pkg.
REQ-028 The store lane and byteenable generation SHALL be the combinational sub-module store_aligner.

Verification
REQ-029 lw with addr=0x1004, waitrequest=0, readdata=0xDEADBEEF -> avm_address=0x1004, byteenable=F; done in cycle 3; data_readdata=0xDEADBEEF; byte_addressing=0.
REQ-030 sb with addr=0x2003, store_data=0x000000A5 -> byteenable=4'b1000, writedata=0xA5A5A5A5, avm_address=0x2000.
REQ-031 lh with addr=0x1001 -> addr_error pulse, no avm_read, stall=0; lw with addr=0x1002 -> same response.
REQ-032 sw with waitrequest held high for 5 cycles -> avm_write held with stable outputs for 6 cycles of ACCESS, stall high throughout, done once.
REQ-033 reset_n asserted mid-ACCESS -> avm_read=0 asynchronously, no done pulse, next lw completes normally.
REQ-034 mem_read=mem_write=1 -> addr_error pulse and no bus strobe.
